// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter. Inhibits the bus,
//               issues a start bit, shifts out 8 data bits LSB-first plus odd
//               parity on device clock falls, releases for the stop bit and
//               checks the device ACK. Open-drain style: *_oe=1 pulls low.
// Options     : define PS2_TX_RETRY_EN to retry a failed frame up to two more
//               times before reporting tx_error.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0] c_inhLast = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  c_toLast  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] c_fltLast = FLT_W'(FILTER_LEN - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_BITS      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic [2:0]       w_failState;
    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic             r_clkFilt;
    logic             r_clkFiltD;
    logic [FLT_W-1:0] r_filtCnt;
    logic             w_fall;
    logic             w_timeout;
    logic             w_accept;
    logic [8:0]       r_shift;
    logic [3:0]       r_bitCnt;
    logic [INH_W-1:0] r_inhCnt;
    logic [TO_W-1:0]  r_timeout;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]       r_byte;
    logic [1:0]       r_retryCnt;
`endif

    assign w_accept  = (r_state == S_IDLE) && tx_start;
    assign w_fall    = r_clkFiltD & ~r_clkFilt;
    assign w_timeout = (r_timeout == c_toLast);

    // Two-flop synchronizers for both pins; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_in};
            r_dataSync <= {r_dataSync[0], ps2_data_in};
        end
    end

    // Clock glitch filter: flip the level only after FILTER_LEN differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkFilt  <= 1'b1;
            r_clkFiltD <= 1'b1;
            r_filtCnt  <= '0;
        end else begin
            r_clkFiltD <= r_clkFilt;
            if (r_clkSync[1] == r_clkFilt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == c_fltLast) begin
                r_clkFilt <= r_clkSync[1];
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FLT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; failures either retry the frame or report an error
    always_comb begin
        w_failState = S_ERROR;
`ifdef PS2_TX_RETRY_EN
        if (r_retryCnt != 2'd2) begin
            w_failState = S_INHIBIT;
        end
`endif
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_start) w_nextState = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (r_inhCnt == c_inhLast) w_nextState = S_REQ;
            end
            S_REQ: begin
                if (w_timeout)   w_nextState = w_failState;
                else if (w_fall) w_nextState = S_BITS;
            end
            S_BITS: begin
                if (w_timeout)                         w_nextState = w_failState;
                else if (w_fall && r_bitCnt == 4'd8)   w_nextState = S_ACK;
            end
            S_ACK: begin
                if (w_timeout)   w_nextState = w_failState;
                else if (w_fall) w_nextState = r_dataSync[1] ? w_failState : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // A clean bus idle wins over a coincident timeout
                if (r_clkFilt && r_dataSync[1]) w_nextState = S_DONE;
                else if (w_timeout)             w_nextState = w_failState;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Moore outputs; DONE/ERROR are single-cycle pulse states with lines released
    always_comb begin
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (r_state)
            S_INHIBIT: begin
                tx_busy    = 1'b1;
                ps2_clk_oe = 1'b1;
            end
            S_REQ: begin
                tx_busy     = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_BITS: begin
                tx_busy     = 1'b1;
                ps2_data_oe = ~r_shift[0];
            end
            S_ACK, S_WAIT_IDLE: tx_busy  = 1'b1;
            S_DONE:             tx_done  = 1'b1;
            S_ERROR:            tx_error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shift register, bit/inhibit/timeout counters, retry bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_inhCnt  <= '0;
            r_timeout <= '0;
`ifdef PS2_TX_RETRY_EN
            r_byte     <= '0;
            r_retryCnt <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_shift <= {~^tx_data, tx_data};
            end else if (r_state == S_BITS && w_fall) begin
                r_shift <= {1'b1, r_shift[8:1]};
`ifdef PS2_TX_RETRY_EN
            end else if (r_state == S_INHIBIT) begin
                r_shift <= {~^r_byte, r_byte};
`endif
            end

            if (r_state != S_BITS)  r_bitCnt <= '0;
            else if (w_fall)        r_bitCnt <= r_bitCnt + 4'd1;

            if (r_state == S_INHIBIT && w_nextState == S_INHIBIT) r_inhCnt <= r_inhCnt + INH_W'(1);
            else                                                   r_inhCnt <= '0;

            // Runs from bus release to frame end, saturating at its terminal value
            if (r_state == S_IDLE || r_state == S_INHIBIT || r_state == S_DONE || r_state == S_ERROR)
                r_timeout <= '0;
            else if (!w_timeout)
                r_timeout <= r_timeout + TO_W'(1);

`ifdef PS2_TX_RETRY_EN
            if (w_accept) begin
                r_byte     <= tx_data;
                r_retryCnt <= '0;
            end else if (r_state != S_IDLE && r_state != S_INHIBIT && w_nextState == S_INHIBIT) begin
                r_retryCnt <= r_retryCnt + 2'd1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with an open-drain bus
//               model and a PS/2 device model (ACK, NACK, silent device).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 2500;
    localparam int TO  = 3000;
    localparam int HP  = 40;     // device clock half-period in clk cycles
`ifdef PS2_TX_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;
    localparam int O_DONE  = 1;
    localparam int O_ERR   = 2;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic       expParity;
        bit         injectAA;
        bit         startOnDone;
        int         expOutcome;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2ClkIn, ps2DataIn;
    logic       devClkLow  = 1'b0;
    logic       devDataLow = 1'b0;

    int   nVec = 0;
    int   nErr = 0;
    int   doneCnt = 0;
    int   errCnt  = 0;
    logic prevPulse = 1'b0;
    logic expBits[$];
    int   expOutcome[$];
    vec_t vecs[6];

    assign ps2ClkIn  = ~(ps2_clk_oe | devClkLow);
    assign ps2DataIn = ~(ps2_data_oe | devDataLow);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(ps2ClkIn),
        .ps2_data_in(ps2DataIn),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: done/error must be exclusive, one cycle wide, busy low
    always @(negedge clk) begin
        if (tx_done)  doneCnt++;
        if (tx_error) errCnt++;
        if (tx_done || tx_error) begin
            nVec++;
            if ((tx_done && tx_error) || prevPulse || tx_busy) begin
                nErr++;
                $display("FAIL pulse_shape: done=%b error=%b busy=%b prev=%b, expected single exclusive pulse with busy=0",
                         tx_done, tx_error, tx_busy, prevPulse);
            end
        end
        prevPulse = tx_done | tx_error;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulseStart(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic pushFrame(input logic [7:0] d, input logic par);
        expBits.delete();
        for (int b = 0; b < 8; b++) expBits.push_back(d[b]);
        expBits.push_back(par);
        expBits.push_back(1'b1);
    endtask

    // Entered on the first cycle the host holds the clock low
    task automatic inhibitPhase();
        int n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("start_bit", ps2DataIn, 0);
    endtask

    task automatic devPulse(input int i, input vec_t v);
        logic b;
        devClkLow = 1'b1;
        for (int c = 0; c < HP; c++) begin
            @(negedge clk);
            tx_start = (v.injectAA && i == 4 && c == HP / 2);
            if (tx_start) tx_data = 8'hAA;
        end
        tx_start  = 1'b0;
        devClkLow = 1'b0;
        b = expBits.pop_front();
        check($sformatf("frame_bit%0d", i), ps2DataIn, b);
        repeat (HP) @(negedge clk);
    endtask

    // 11th clock: device ACKs (or not); returns early on retry inhibit or a pulse
    task automatic ackPulse(input vec_t v);
        if (v.mode == M_ACK) devDataLow = 1'b1;
        devClkLow = 1'b1;
        for (int c = 0; c < 2 * HP; c++) begin
            @(negedge clk);
            if (c == HP - 1) begin
                devClkLow  = 1'b0;
                devDataLow = 1'b0;
            end
            if (ps2_clk_oe || tx_error) begin
                devClkLow  = 1'b0;
                devDataLow = 1'b0;
                break;
            end
            if (tx_done) begin
                if (v.startOnDone) begin
                    tx_start = 1'b1;
                    tx_data  = 8'h55;
                    @(negedge clk);
                    tx_start = 1'b0;
                end
                break;
            end
        end
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
    endtask

    task automatic runFrame(input vec_t v);
        int attempts, d0, e0, k, exp;
        attempts = (v.mode == M_ACK) ? 1 : RETRIES + 1;
        d0 = doneCnt;
        e0 = errCnt;
        expOutcome.push_back(v.expOutcome);
        pulseStart(v.data);
        check("clk_oe_latency", ps2_clk_oe, 1);
        check("busy_on_accept", tx_busy, 1);
        for (int a = 0; a < attempts; a++) begin
            pushFrame(v.data, v.expParity);
            inhibitPhase();
            if (v.mode == M_NOCLK) begin
                k = 0;
                while (!(tx_error || ps2_clk_oe) && k < TO + 100) begin
                    @(negedge clk);
                    k++;
                end
                check("timeout_cycles", k, TO);
                if (a == attempts - 1) check("timeout_error", tx_error, 1);
                else                   check("retry_inhibit", ps2_clk_oe, 1);
            end else begin
                repeat (HP) @(negedge clk);
                for (int i = 0; i < 10; i++) devPulse(i, v);
                ackPulse(v);
                if (a != attempts - 1) check("nack_retry_inhibit", ps2_clk_oe, 1);
            end
        end
        k = 0;
        while (doneCnt + errCnt == d0 + e0 && k < 4 * HP) begin
            @(negedge clk);
            k++;
        end
        exp = expOutcome.pop_front();
        check("done_count", doneCnt - d0, (exp == O_DONE) ? 1 : 0);
        check("error_count", errCnt - e0, (exp == O_ERR) ? 1 : 0);
        repeat (30) @(negedge clk);
        check("idle_clk_oe", ps2_clk_oe, 0);
        check("idle_data_oe", ps2_data_oe, 0);
        check("idle_busy", tx_busy, 0);
        check("no_extra_pulse", doneCnt + errCnt - d0 - e0, 1);
    endtask

    initial begin
        int d0, e0;
        vecs[0] = '{data: 8'hED, mode: M_ACK,   expParity: 1'b1, injectAA: 1'b0, startOnDone: 1'b0, expOutcome: O_DONE};
        vecs[1] = '{data: 8'hF4, mode: M_ACK,   expParity: 1'b0, injectAA: 1'b0, startOnDone: 1'b0, expOutcome: O_DONE};
        vecs[2] = '{data: 8'hFF, mode: M_ACK,   expParity: 1'b1, injectAA: 1'b0, startOnDone: 1'b1, expOutcome: O_DONE};
        vecs[3] = '{data: 8'h00, mode: M_NOCLK, expParity: 1'b1, injectAA: 1'b0, startOnDone: 1'b0, expOutcome: O_ERR};
        vecs[4] = '{data: 8'hED, mode: M_NACK,  expParity: 1'b1, injectAA: 1'b0, startOnDone: 1'b0, expOutcome: O_ERR};
        vecs[5] = '{data: 8'hED, mode: M_ACK,   expParity: 1'b1, injectAA: 1'b1, startOnDone: 1'b0, expOutcome: O_DONE};

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 6; v++) runFrame(vecs[v]);

        // Reset in the middle of bit 4 of an 0xED frame
        d0 = doneCnt;
        e0 = errCnt;
        pushFrame(8'hED, 1'b1);
        pulseStart(8'hED);
        inhibitPhase();
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 4; i++) devPulse(i, vecs[0]);
        devClkLow = 1'b1;
        repeat (HP / 2) @(negedge clk);
        check("bit4_driving_busy", tx_busy, 1);
        reset     = 1'b1;
        devClkLow = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_busy", tx_busy, 0);
        check("midrst_pulses", tx_done | tx_error, 0);
        repeat (4 * HP) @(negedge clk);
        check("midrst_no_later_pulse", doneCnt + errCnt - d0 - e0, 0);
        check("midrst_stays_idle", ps2_clk_oe, 0);

        runFrame(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
